// File: rtl/thermo_pkg.sv
// Shared definitions for the HVAC controller: FSM state encoding,
// default timing constants and small elaboration-time helpers.
package thermo_pkg;

   // Display-visible state encoding; values are fixed for the front panel.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAT    = 3'd1,
      ST_COOL    = 3'd2,
      ST_PURGE   = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   // Default timing: one tick per second at 100 MHz.
   localparam int DEF_TICK_DIV    = 100000000;
   localparam int DEF_HYST        = 2;
   localparam int DEF_MIN_RUN     = 60;
   localparam int DEF_FAN_OVERRUN = 30;
   localparam int DEF_MIN_OFF     = 120;

   // Largest of three dwell limits; sizes the shared tick timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int timer_width(input int max_val);
      int w;
      if (max_val < 1) begin
         w = 1;
      end else begin
         w = $clog2(max_val + 1);
      end
      return w;
   endfunction

endpackage

// File: rtl/hvac_controller_chk.sv
// Safety properties of the HVAC controller outputs, kept apart from the
// design so they can be attached wherever the controller is used.
module hvac_controller_chk
   import thermo_pkg::*;
(
   input logic       clk,
   input logic       Reset,
   input logic       Heat,
   input logic       Cool,
   input logic       Fan,
   input logic [2:0] State
);

   // Heater and cooler must never be commanded together, even mid-reset.
   always_comb begin
      a_heat_cool_excl : assert (!(Heat && Cool));
   end

   // Heat to cool (and back) must pass through purge and lockout.
   a_no_heat_to_cool : assert property (@(posedge clk) disable iff (Reset)
      (State == ST_HEAT) |=> (State != ST_COOL));
   a_no_cool_to_heat : assert property (@(posedge clk) disable iff (Reset)
      (State == ST_COOL) |=> (State != ST_HEAT));

   // The blower runs whenever heating or cooling is active.
   a_fan_with_load : assert property (@(posedge clk) disable iff (Reset)
      (Heat || Cool) |-> Fan);

   // Only the five defined encodings may ever be displayed.
   a_state_legal : assert property (@(posedge clk) State <= 3'd4);

endmodule

// File: rtl/tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 and flags the last count.
// A synchronous clear restarts the count so every FSM state begins on a
// fresh tick boundary.
module tick_gen
   import thermo_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   // Free-running modulo-TICK_DIV counter, restarted on clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/hvac_controller.sv
// HVAC controller: thermostat FSM with hysteresis, minimum run time,
// fan overrun purge and compressor lockout. Outputs are registered and
// follow the registered state, so they move one cycle after the
// condition that caused a transition is sampled.
module hvac_controller
   import thermo_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int HYST        = DEF_HYST,
   parameter int MIN_RUN     = DEF_MIN_RUN,
   parameter int FAN_OVERRUN = DEF_FAN_OVERRUN,
   parameter int MIN_OFF     = DEF_MIN_OFF
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [7:0] CurrentTemp,
   input  logic [7:0] ChangedTemp,
   output logic       Heat,
   output logic       Cool,
   output logic       Fan,
   output logic [2:0] State
);

   localparam int               TMR_MAX = max3(MIN_RUN, FAN_OVERRUN, MIN_OFF);
   localparam int               TMR_W   = timer_width(TMR_MAX);
   localparam logic [TMR_W-1:0] TMR_SAT = {TMR_W{1'b1}};
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
   localparam logic [TMR_W-1:0] RUN_T   = TMR_W'(MIN_RUN);
   localparam logic [TMR_W-1:0] PURGE_T = TMR_W'(FAN_OVERRUN);
   localparam logic [TMR_W-1:0] OFF_T   = TMR_W'(MIN_OFF);
   localparam logic [8:0]       HYST_9  = 9'(HYST);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [TMR_W-1:0] timer_r;
   logic [TMR_W-1:0] timer_eff_s;
   logic             tick_s;
   logic             trans_s;
   logic [8:0]       cur_9_s;
   logic [8:0]       set_9_s;
   logic             heat_dem_s;
   logic             cool_dem_s;

   // Demand comparisons widened to 9 bits so setpoint +/- band never wraps.
   always_comb begin
      cur_9_s    = {1'b0, CurrentTemp};
      set_9_s    = {1'b0, ChangedTemp};
      heat_dem_s = ((cur_9_s + HYST_9) < set_9_s);
      cool_dem_s = (cur_9_s > (set_9_s + HYST_9));
   end

   // Timer value including the tick landing this cycle, so a state exits
   // on the very edge its last tick completes (dwell = N * TICK_DIV).
   always_comb begin
      if (tick_s && (timer_r != TMR_SAT)) begin
         timer_eff_s = timer_r + TMR_ONE;
      end else begin
         timer_eff_s = timer_r;
      end
   end

   // Next-state decision; PURGE and LOCKOUT ignore Enable so they always finish.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Enable && heat_dem_s) begin
               state_nxt_s = ST_HEAT;
            end else if (Enable && cool_dem_s) begin
               state_nxt_s = ST_COOL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HEAT: begin
            if (!Enable || ((CurrentTemp >= ChangedTemp) && (timer_eff_s >= RUN_T))) begin
               state_nxt_s = ST_PURGE;
            end else begin
               state_nxt_s = ST_HEAT;
            end
         end
         ST_COOL: begin
            if (!Enable || ((CurrentTemp <= ChangedTemp) && (timer_eff_s >= RUN_T))) begin
               state_nxt_s = ST_PURGE;
            end else begin
               state_nxt_s = ST_COOL;
            end
         end
         ST_PURGE: begin
            if (timer_eff_s >= PURGE_T) begin
               state_nxt_s = ST_LOCKOUT;
            end else begin
               state_nxt_s = ST_PURGE;
            end
         end
         ST_LOCKOUT: begin
            if (timer_eff_s >= OFF_T) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LOCKOUT;
            end
         end
         default: begin
            state_nxt_s = ST_LOCKOUT;
         end
      endcase
      trans_s = (state_nxt_s != state_r);
   end

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (Reset),
      .clr  (trans_s),
      .tick (tick_s)
   );

   // State, dwell timer and Moore outputs; reset lands in a full lockout.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_r <= ST_LOCKOUT;
         timer_r <= '0;
         Heat    <= 1'b0;
         Cool    <= 1'b0;
         Fan     <= 1'b0;
         State   <= 3'd4;
      end else begin
         state_r <= state_nxt_s;
         if (trans_s) begin
            timer_r <= '0;
         end else begin
            timer_r <= timer_eff_s;
         end
         Heat  <= (state_nxt_s == ST_HEAT);
         Cool  <= (state_nxt_s == ST_COOL);
         Fan   <= (state_nxt_s == ST_HEAT) || (state_nxt_s == ST_COOL) ||
                  (state_nxt_s == ST_PURGE);
         State <= state_nxt_s;
      end
   end

endmodule

// File: tb/tb_hvac_controller.sv
// Self-checking bench: directed scenarios plus randomized temperature,
// setpoint, enable and reset activity, compared every cycle against a
// dwell-time reference model.
module tb_hvac_controller;

   localparam int TD  = 4;
   localparam int HY  = 2;
   localparam int MR  = 3;
   localparam int FO  = 2;
   localparam int MO  = 2;

   logic       clk;
   logic       Reset;
   logic       Enable;
   logic [7:0] CurrentTemp;
   logic [7:0] ChangedTemp;
   logic       Heat;
   logic       Cool;
   logic       Fan;
   logic [2:0] State;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode name as number, cycles spent in it so far.
   int m_state;
   int m_cycles;

   hvac_controller #(
      .TICK_DIV    (TD),
      .HYST        (HY),
      .MIN_RUN     (MR),
      .FAN_OVERRUN (FO),
      .MIN_OFF     (MO)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .Enable      (Enable),
      .CurrentTemp (CurrentTemp),
      .ChangedTemp (ChangedTemp),
      .Heat        (Heat),
      .Cool        (Cool),
      .Fan         (Fan),
      .State       (State)
   );

   hvac_controller_chk u_chk (
      .clk   (clk),
      .Reset (Reset),
      .Heat  (Heat),
      .Cool  (Cool),
      .Fan   (Fan),
      .State (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Model advance for one clock edge: whole seconds elapsed decide exits.
   task automatic model_step();
      int cur, sp, secs, nxt;
      bit heat_d, cool_d;
      cur    = int'(CurrentTemp);
      sp     = int'(ChangedTemp);
      secs   = (m_cycles + 1) / TD;
      heat_d = (cur + HY) < sp;
      cool_d = cur > (sp + HY);
      nxt    = m_state;
      case (m_state)
         0: if (Enable && heat_d) nxt = 1; else if (Enable && cool_d) nxt = 2;
         1: if (!Enable || (cur >= sp && secs >= MR)) nxt = 3;
         2: if (!Enable || (cur <= sp && secs >= MR)) nxt = 3;
         3: if (secs >= FO) nxt = 4;
         4: if (secs >= MO) nxt = 0;
         default: nxt = 4;
      endcase
      if (nxt != m_state) begin
         m_state  = nxt;
         m_cycles = 0;
      end else begin
         m_cycles = m_cycles + 1;
      end
   endtask

   task automatic check_outputs(input string where);
      check_eq({where, "_state"}, int'(State), m_state);
      check_eq({where, "_heat"},  int'(Heat),  int'(m_state == 1));
      check_eq({where, "_cool"},  int'(Cool),  int'(m_state == 2));
      check_eq({where, "_fan"},   int'(Fan),   int'(m_state >= 1 && m_state <= 3));
   endtask

   // Reset raised between edges must clear outputs without waiting for a clock.
   task automatic do_reset();
      #1;
      Reset = 1'b1;
      #1;
      check_eq("async_rst_heat",  int'(Heat),  0);
      check_eq("async_rst_cool",  int'(Cool),  0);
      check_eq("async_rst_fan",   int'(Fan),   0);
      check_eq("async_rst_state", int'(State), 4);
      m_state  = 4;
      m_cycles = 0;
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic step_cycle(input bit en, input logic [7:0] cur, input logic [7:0] sp,
                             input bit rst_pulse);
      @(negedge clk);
      if (rst_pulse) begin
         do_reset();
      end
      Enable      = en;
      CurrentTemp = cur;
      ChangedTemp = sp;
      check_outputs("cyc");
      @(posedge clk);
      model_step();
   endtask

   typedef struct {
      int   len;
      bit   en;
      int   cur;
      int   sp;
      bit   rst;
   } seg_t;

   seg_t dir_tab[$];

   initial begin
      Reset       = 1'b1;
      Enable      = 1'b1;
      CurrentTemp = 8'd70;
      ChangedTemp = 8'd70;
      m_state     = 4;
      m_cycles    = 0;

      @(negedge clk);
      check_eq("reset_state", int'(State), 4);
      check_eq("reset_heat",  int'(Heat),  0);
      check_eq("reset_cool",  int'(Cool),  0);
      check_eq("reset_fan",   int'(Fan),   0);
      Reset = 1'b0;
      @(posedge clk);
      model_step();

      // Directed: lockout after reset, heat cycle, hysteresis edges,
      // cool with shutdown, wrap boundaries, reset mid-heat.
      dir_tab = '{
         '{12, 1'b1, 70,  70,  1'b0},
         '{8,  1'b1, 65,  70,  1'b0},
         '{30, 1'b1, 70,  70,  1'b0},
         '{6,  1'b1, 68,  70,  1'b0},
         '{40, 1'b1, 67,  70,  1'b0},
         '{6,  1'b1, 72,  70,  1'b0},
         '{3,  1'b1, 73,  70,  1'b0},
         '{30, 1'b0, 73,  70,  1'b0},
         '{6,  1'b1, 255, 254, 1'b0},
         '{6,  1'b1, 0,   1,   1'b0},
         '{5,  1'b1, 60,  70,  1'b0},
         '{20, 1'b1, 60,  70,  1'b1},
         '{20, 1'b1, 70,  70,  1'b0}
      };
      foreach (dir_tab[i]) begin
         for (int c = 0; c < dir_tab[i].len; c++) begin
            step_cycle(dir_tab[i].en, 8'(dir_tab[i].cur), 8'(dir_tab[i].sp),
                       dir_tab[i].rst && (c == 0));
         end
      end

      // Randomized segments of held inputs with occasional reset pulses.
      for (int s = 0; s < 150; s++) begin
         int len, mode, cur, sp;
         bit en;
         len  = int'($urandom_range(1, 30));
         mode = int'($urandom_range(0, 19));
         en   = ($urandom_range(0, 9) != 0);
         if (mode == 0) begin
            cur = 255; sp = 254;
         end else if (mode == 1) begin
            cur = 0; sp = 1;
         end else if (mode == 2) begin
            cur = int'($urandom_range(0, 255));
            sp  = int'($urandom_range(0, 255));
         end else begin
            sp  = int'($urandom_range(60, 80));
            cur = sp + int'($urandom_range(0, 14)) - 7;
         end
         for (int c = 0; c < len; c++) begin
            step_cycle(en, 8'(cur), 8'(sp), ($urandom_range(0, 299) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hvac_controller.md
HVAC_CONTROLLER -- requirements
Module: hvac_controller

Interface
REQ-001 Parameter TICK_DIV, 100000000, clk cycles per timing tick (1 s at 100 MHz); legal range is 2 or more.
REQ-002 Parameter HYST, 2, hysteresis band in degrees.
REQ-003 Parameter MIN_RUN, 60, minimum ticks in HEAT/COOL before a satisfied exit.
REQ-004 Parameter FAN_OVERRUN, 30, ticks the fan runs alone after HEAT/COOL.
REQ-005 Parameter MIN_OFF, 120, lockout ticks before a new HEAT/COOL start.
REQ-006 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 Port Reset  input  1  asynchronous, active-high reset.
REQ-008 Port Enable  input  1  system on; low requests shutdown.
REQ-009 Port CurrentTemp  input  8  measured temperature, unsigned degrees.
REQ-010 Port ChangedTemp  input  8  user setpoint, unsigned degrees.
REQ-011 Port Heat  output  1  heater command.
REQ-012 Port Cool  output  1  cooler command.
REQ-013 Port Fan  output  1  blower command.
REQ-014 Port State  output  3  current FSM state encoding, for the display.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE=0, HEAT=1, COOL=2, PURGE=3, LOCKOUT=4.
REQ-016 Heat demand SHALL be CurrentTemp + HYST < ChangedTemp, evaluated 9-bit, so there is no wrap.
REQ-017 Cool demand SHALL be CurrentTemp > ChangedTemp + HYST, evaluated 9-bit, so 255+HYST does not wrap.
REQ-018 IDLE SHALL go to HEAT when Enable and heat demand hold, else to COOL when Enable and cool demand hold, else stay in IDLE.
REQ-019 HEAT SHALL go to PURGE immediately when Enable=0, or when CurrentTemp >= ChangedTemp and run timer >= MIN_RUN.
REQ-020 COOL SHALL go to PURGE immediately when Enable=0, or when CurrentTemp <= ChangedTemp and run timer >= MIN_RUN.
REQ-021 PURGE SHALL go to LOCKOUT when timer = FAN_OVERRUN.
REQ-022 LOCKOUT SHALL go to IDLE when timer = MIN_OFF.
REQ-023 LOCKOUT and PURGE SHALL complete regardless of Enable.
REQ-024 A setpoint change SHALL take effect on the next cycle's comparison.
REQ-025 A tick prescaler SHALL count 0..TICK_DIV-1 and pulse tick for one cycle at TICK_DIV-1.
REQ-026 The prescaler SHALL clear on every state transition, so each timed state dwells exactly N*TICK_DIV cycles.
REQ-027 The tick timer SHALL clear on state entry, increment on tick, and saturate at its maximum.
REQ-028 The tick timer width SHALL cover max(MIN_RUN, FAN_OVERRUN, MIN_OFF).
REQ-029 Outputs SHALL be Moore-decoded from the registered state: Heat=(HEAT), Cool=(COOL), Fan=(HEAT|COOL|PURGE), State=state.
REQ-030 Outputs SHALL change one cycle after the transition condition is sampled.
REQ-031 Heat and Cool SHALL never be high in the same cycle.
REQ-032 A direct HEAT<->COOL transition SHALL be impossible.

Reset
REQ-033 Reset SHALL asynchronously force state=LOCKOUT, prescaler=0, timer=0, Heat=Cool=Fan=0, State=4.
REQ-034 After reset deassertion the block SHALL serve a full MIN_OFF lockout before IDLE.
REQ-035 Reset asserted mid-HEAT/COOL SHALL drop Heat/Cool/Fan in the same cycle, with no purge.

Structure
REQ-036 Package thermo_pkg SHALL hold the state enumeration/encoding and the default parameter constants.
REQ-037 One sub-module, tick_gen (prescaler with synchronous clear input and tick output), SHALL be used.
REQ-038 The FSM and timer SHALL live in hvac_controller.

Verification (TICK_DIV=4, HYST=2, MIN_RUN=3, FAN_OVERRUN=2, MIN_OFF=2)
REQ-039 Reset release, Enable=1, Cur=70, Set=70 -> State=4 for 8 cycles, then State=0, all outputs 0.
REQ-040 From IDLE, Cur=65, Set=70 -> next cycle Heat=1, Fan=1; Cur set to 70 at 2 ticks -> Heat held until 12 cycles in HEAT, then PURGE (Fan only) 8 cycles, LOCKOUT 8 cycles, IDLE.
REQ-041 Cur=68, Set=70 (boundary) -> stays IDLE; Cur=67 -> HEAT; Cur=72 -> IDLE; Cur=73 -> COOL.
REQ-042 In COOL, Enable=0 after 1 cycle -> next cycle Cool=0, Fan=1, State=3.
REQ-043 Cur=255, Set=254 -> no cool (no wrap); Cur=0, Set=1 -> no heat.
REQ-044 Reset pulse mid-HEAT -> Heat=Fan=0 asynchronously, State=4; Heat=Cool=1 never observed (assertion).
